// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among 8 requesters; drives sel, one-hot gnt and muxed y.
// Optional forced rotation after MAX_HOLD contended cycles when ARB_TIMEOUT_EN is defined.
module mux8_rr_arbiter #(
  parameter int NREQ     = 8,
  parameter int SELW     = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] d,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_vld,
  output logic [SELW-1:0] sel,
  output logic            y
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic              vld_reg, vld_next;
  logic [SELW-1:0]   sel_reg, sel_next;
  logic [SELW-1:0]   ptr_reg, ptr_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

  logic [NREQ-1:0]   others;
  logic [SELW-1:0]   nptr;
  logic [NREQ-1:0]   pick_vec;
  logic [SELW-1:0]   pick_base;
  logic [SELW-1:0]   pick_idx;
  logic [NREQ-1:0]   pick_onehot;
  logic              timeout;

  // Lowest offset from start wins, so the scan runs high-to-low and overwrites.
  function automatic logic [SELW-1:0] pick(input logic [NREQ-1:0] r, input logic [SELW-1:0] start);
    logic [SELW-1:0] idx;
    logic [SELW-1:0] res;
    res = start;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = start + SELW'(off);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  assign others    = req & ~gnt_reg;
  assign nptr      = sel_reg + 1'b1;
  assign pick_vec  = (state_reg == IDLE) ? req : others;
  assign pick_base = (state_reg == IDLE) ? ptr_reg : nptr;
  assign pick_idx  = pick(pick_vec, pick_base);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == SELW'(gi));
    end
  endgenerate

`ifdef ARB_TIMEOUT_EN
  assign timeout = (hold_cnt_reg == HOLD_LAST) && (|others);
`else
  logic unused_hold;
  assign timeout     = 1'b0;
  assign unused_hold = ^hold_cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      vld_reg      <= 1'b0;
      sel_reg      <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      vld_reg      <= vld_next;
      sel_reg      <= sel_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    vld_next      = vld_reg;
    sel_next      = sel_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next    = GRANT;
          gnt_next      = pick_onehot;
          sel_next      = pick_idx;
          vld_next      = 1'b1;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        if (req[sel_reg] && !timeout) begin
          if (hold_cnt_reg != HOLD_LAST) hold_cnt_next = hold_cnt_reg + 1'b1;
        end else begin
          // Owner released or was preempted: restart the search after it.
          ptr_next      = nptr;
          hold_cnt_next = '0;
          if (|others) begin
            gnt_next = pick_onehot;
            sel_next = pick_idx;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            vld_next   = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt     = gnt_reg;
  assign gnt_vld = vld_reg;
  assign sel     = sel_reg;
  assign y       = vld_reg & d[sel_reg];

endmodule
